// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: free-running pixel/line counters feeding a
// registered flag stage (sync, blanking, data-enable, strobes) that lags them by one ce tick.
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CW       = 12
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          ce_pix,
    output logic          hsync,
    output logic          vsync,
    output logic          hblank,
    output logic          vblank,
    output logic          de,
    output logic [CW-1:0] counter_x,
    output logic [CW-1:0] counter_y,
    output logic          line_start,
    output logic          frame_start
);

    localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] H_SS_C   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SE_C   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] H_LAST_C = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_SS_C   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SE_C   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] V_LAST_C = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic          HS_ON    = (HS_POL != 0);
    localparam logic          VS_ON    = (VS_POL != 0);

    logic [CW-1:0] hc_q, hc_d, vc_q, vc_d;
    logic [CW-1:0] cx_q, cx_d, cy_q, cy_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d;
    logic          hblank_q, hblank_d, vblank_q, vblank_d;
    logic          de_q, de_d, ls_q, ls_d, fs_q, fs_d;
    logic          hs_act, vs_act, hs_lead, hb_now, vb_now;

    always_comb begin
        hb_now  = (hc_q >= H_ACT_C);
        vb_now  = (vc_q >= V_ACT_C);
        hs_act  = (hc_q >= H_SS_C) && (hc_q < H_SE_C);
        vs_act  = (vc_q >= V_SS_C) && (vc_q < V_SE_C);
        // vsync is sampled only on the hsync leading edge so both edges line up
        hs_lead = hs_act && (hsync_q != HS_ON);

        hc_d     = hc_q;
        vc_d     = vc_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        hsync_d  = hsync_q;
        vsync_d  = vsync_q;
        hblank_d = hblank_q;
        vblank_d = vblank_q;
        de_d     = de_q;
        ls_d     = ls_q;
        fs_d     = fs_q;

        if (ce_pix) begin
            if (hc_q == H_LAST_C) begin
                hc_d = '0;
                vc_d = (vc_q == V_LAST_C) ? '0 : vc_q + CW'(1);
            end else begin
                hc_d = hc_q + CW'(1);
            end
            cx_d     = hc_q;
            cy_d     = vc_q;
            hblank_d = hb_now;
            vblank_d = vb_now;
            de_d     = ~hb_now & ~vb_now;
            ls_d     = (hc_q == '0);
            fs_d     = (hc_q == '0) && (vc_q == '0);
            hsync_d  = hs_act ? HS_ON : ~HS_ON;
            if (hs_lead) begin
                vsync_d = vs_act ? VS_ON : ~VS_ON;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            hc_q     <= '0;
            vc_q     <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            hsync_q  <= ~HS_ON;
            vsync_q  <= ~VS_ON;
            hblank_q <= 1'b1;
            vblank_q <= 1'b1;
            de_q     <= 1'b0;
            ls_q     <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            hc_q     <= hc_d;
            vc_q     <= vc_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            hblank_q <= hblank_d;
            vblank_q <= vblank_d;
            de_q     <= de_d;
            ls_q     <= ls_d;
            fs_q     <= fs_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign hblank      = hblank_q;
    assign vblank      = vblank_q;
    assign de          = de_q;
    assign counter_x   = cx_q;
    assign counter_y   = cy_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench: small 16x8 raster in both sync polarities plus the default 800x525 mode,
// with hand-derived expectations per ce tick.
module tb_video_timing_gen;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic ce_pix = 1'b1;

    always #5 Clk = ~Clk;

    logic       hs0, vs0, hb0, vb0, de0, ls0, fs0;
    logic [4:0] cx0, cy0;
    logic       hs1, vs1, hb1, vb1, de1, ls1, fs1;
    logic [4:0] cx1, cy1;
    logic        hs2, vs2, hb2, vb2, de2, ls2, fs2;
    logic [11:0] cx2, cy2;

    video_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
                       .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
                       .HS_POL(0), .VS_POL(0), .CW(5)) u_dut0 (
        .Clk(Clk), .Reset(Reset), .ce_pix(ce_pix),
        .hsync(hs0), .vsync(vs0), .hblank(hb0), .vblank(vb0), .de(de0),
        .counter_x(cx0), .counter_y(cy0), .line_start(ls0), .frame_start(fs0));

    video_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
                       .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
                       .HS_POL(1), .VS_POL(1), .CW(5)) u_dut1 (
        .Clk(Clk), .Reset(Reset), .ce_pix(ce_pix),
        .hsync(hs1), .vsync(vs1), .hblank(hb1), .vblank(vb1), .de(de1),
        .counter_x(cx1), .counter_y(cy1), .line_start(ls1), .frame_start(fs1));

    video_timing_gen u_dut2 (
        .Clk(Clk), .Reset(Reset), .ce_pix(ce_pix),
        .hsync(hs2), .vsync(vs2), .hblank(hb2), .vblank(vb2), .de(de2),
        .counter_x(cx2), .counter_y(cy2), .line_start(ls2), .frame_start(fs2));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_reset(input string ph);
        chk({ph, " cx0"}, 32'(cx0), 0);
        chk({ph, " cy0"}, 32'(cy0), 0);
        chk({ph, " hs0"}, 32'(hs0), 1);
        chk({ph, " vs0"}, 32'(vs0), 1);
        chk({ph, " hs1"}, 32'(hs1), 0);
        chk({ph, " vs1"}, 32'(vs1), 0);
        chk({ph, " blank0"}, {30'd0, hb0, vb0}, 3);
        chk({ph, " de_ls_fs0"}, {29'd0, de0, ls0, fs0}, 0);
        chk({ph, " hs2"}, 32'(hs2), 1);
    endtask

    // Output of the t-th ce tick after reset release, small mode 16x8.
    task automatic chk_small(input int t, input string ph);
        int   x, y;
        logic hs_on, vs_on;
        string p;
        x = t % 16;
        y = (t / 16) % 8;
        hs_on = (x >= 10) && (x <= 11);
        // vsync flips only at x=10: on from (5,10) up to (6,9)
        vs_on = ((y == 5) && (x >= 10)) || ((y == 6) && (x < 10));
        p = $sformatf("%s t%0d", ph, t);
        chk({p, " cx0"}, 32'(cx0), 32'(x));
        chk({p, " cy0"}, 32'(cy0), 32'(y));
        chk({p, " hb0"}, 32'(hb0), 32'(x >= 8));
        chk({p, " vb0"}, 32'(vb0), 32'(y >= 4));
        chk({p, " de0"}, 32'(de0), 32'((x < 8) && (y < 4)));
        chk({p, " ls0"}, 32'(ls0), 32'(x == 0));
        chk({p, " fs0"}, 32'(fs0), 32'((x == 0) && (y == 0)));
        chk({p, " hs0"}, 32'(hs0), 32'(!hs_on));
        chk({p, " vs0"}, 32'(vs0), 32'(!vs_on));
        chk({p, " hs1"}, 32'(hs1), 32'(hs_on));
        chk({p, " vs1"}, 32'(vs1), 32'(vs_on));
        chk({p, " rest1"}, {17'd0, cx1, cy1, hb1, vb1, de1, ls1, fs1},
            {17'd0, 5'(x), 5'(y), 1'(x >= 8), 1'(y >= 4), 1'((x < 8) && (y < 4)),
             1'(x == 0), 1'((x == 0) && (y == 0))});
    endtask

    initial begin
        // Reset held 3 cycles, then two full frames at ce=1
        Reset = 1'b1; ce_pix = 1'b1;
        repeat (3) tick();
        chk_reset("reset");
        Reset = 1'b0;
        for (int t = 0; t < 256; t++) begin
            tick();
            chk_small(t, "scan");
        end
        $display("phase scan done: %0d/%0d", n_pass, n_checks);

        // ce_pix alternating: every value holds across the idle Clk
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        for (int t = 0; t < 128; t++) begin
            ce_pix = 1'b1;
            tick();
            chk_small(t, "ce_on");
            ce_pix = 1'b0;
            tick();
            chk_small(t, "ce_off");
        end
        ce_pix = 1'b1;
        tick();
        chk_small(128, "ce_wrap");
        $display("phase ce toggle done: %0d/%0d", n_pass, n_checks);

        // Mid-frame reset at x=5,y=6 (vsync active there)
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        for (int t = 0; t <= 101; t++) tick();
        chk_small(101, "pre_rst");
        Reset = 1'b1;
        tick();
        chk_reset("mid_rst");
        Reset = 1'b0;
        tick();
        chk_small(0, "post_rst");
        $display("phase mid reset done: %0d/%0d", n_pass, n_checks);

        // Default 640x480 mode: one full line plus the wrap into line 1
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        for (int t = 0; t < 800; t++) begin
            tick();
            chk($sformatf("dflt x%0d cx", t), 32'(cx2), 32'(t));
            chk($sformatf("dflt x%0d hs", t), 32'(hs2), 32'(!((t >= 656) && (t <= 751))));
            chk($sformatf("dflt x%0d hb", t), 32'(hb2), 32'(t >= 640));
        end
        tick();
        chk("dflt wrap xy", {8'd0, cx2, cy2}, {8'd0, 12'd0, 12'd1});
        chk("dflt wrap ls_fs", {30'd0, ls2, fs2}, 2);
        $display("phase default mode done: %0d/%0d", n_pass, n_checks);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
